// File: rtl/logic_gate_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : logic_gate_checker_if
//  Description : Stimulus/response and result bundle for the gate checker.
//  Revision    : 1.0 - initial release
// ============================================================================
interface logic_gate_checker_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             in_valid;
    logic             in_a;
    logic             in_b;
    logic [6:0]       in_resp;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] vec_count;
    logic [CNT_W-1:0] err_count;
    logic [1:0]       first_err_vec;
    logic [6:0]       first_err_mask;
    // Combination-coverage map; "cover" itself is a reserved word.
    logic [3:0]       cover_bits;

    modport master (
        output start, in_valid, in_a, in_b, in_resp,
        input  in_ready, busy, done, pass, vec_count, err_count,
               first_err_vec, first_err_mask, cover_bits
    );

    modport slave (
        input  start, in_valid, in_a, in_b, in_resp,
        output in_ready, busy, done, pass, vec_count, err_count,
               first_err_vec, first_err_mask, cover_bits
    );
endinterface
`default_nettype wire

// File: rtl/logic_gate_checker.sv
`default_nettype none
// ============================================================================
//  Module      : logic_gate_checker
//  Description : Checks two-input gate library responses against truth table,
//                counts vectors/errors, captures first failure, gives verdict.
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_gate_checker #(
    parameter int NUM_VEC     = 4,
    parameter int CNT_W       = 8,
    parameter int STOP_ON_ERR = 0
) (
    input  wire logic           clk,
    input  wire logic           rst,
    logic_gate_checker_if.slave bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [CNT_W-1:0] c_NUM_VEC    = CNT_W'(NUM_VEC);
    localparam logic             c_STOP_ERR   = (STOP_ON_ERR != 0);
    localparam logic             c_NEED_COVER = (NUM_VEC >= 4);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;

    logic [CNT_W-1:0] r_vec_count;
    logic [CNT_W-1:0] r_err_count;
    logic [1:0]       r_first_err_vec;
    logic [6:0]       r_first_err_mask;
    logic [3:0]       r_cover;
    logic             r_pass;

    logic             w_in_ready;
    logic             w_busy;
    logic             w_done;
    logic             w_start_run;
    logic             w_accept;
    logic [6:0]       w_expected;
    logic [6:0]       w_mask;
    logic             w_err;
    logic [CNT_W-1:0] w_vec_next;
    logic [3:0]       w_cover_next;
    logic             w_finish;
    logic             w_pass_next;

    // Expected bit order [6:0]: xnor, xor, nor, nand, not(a), or, and.
    assign w_expected = {~(bus.in_a ^ bus.in_b), bus.in_a ^ bus.in_b,
                         ~(bus.in_a | bus.in_b), ~(bus.in_a & bus.in_b),
                         ~bus.in_a, bus.in_a | bus.in_b, bus.in_a & bus.in_b};
    assign w_mask       = bus.in_resp ^ w_expected;
    assign w_err        = |w_mask;
    assign w_accept     = bus.in_valid & w_in_ready;
    assign w_start_run  = bus.start & ((r_state == c_IDLE) | (r_state == c_DONE));
    assign w_vec_next   = r_vec_count + 1'b1;
    assign w_cover_next = r_cover | (4'b0001 << {bus.in_a, bus.in_b});
    assign w_finish     = w_accept & ((w_vec_next == c_NUM_VEC) | (c_STOP_ERR & w_err));
    assign w_pass_next  = (r_err_count == '0) & ~w_err &
                          (~c_NEED_COVER | (w_cover_next == 4'hF));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (bus.start) w_state_next = c_RUN;
            c_RUN:   if (w_finish)  w_state_next = c_DONE;
            c_DONE:  if (bus.start) w_state_next = c_RUN;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            c_RUN: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
            end
            c_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec_count      <= '0;
            r_err_count      <= '0;
            r_first_err_vec  <= '0;
            r_first_err_mask <= '0;
            r_cover          <= '0;
            r_pass           <= 1'b0;
        end else if (w_start_run) begin
            r_vec_count      <= '0;
            r_err_count      <= '0;
            r_first_err_vec  <= '0;
            r_first_err_mask <= '0;
            r_cover          <= '0;
            r_pass           <= 1'b0;
        end else if (w_accept) begin
            r_vec_count <= w_vec_next;
            r_cover     <= w_cover_next;
            if (w_err) begin
                if (r_err_count != '1) begin
                    r_err_count <= r_err_count + 1'b1;
                end
                // A zero error count means no mismatch has been seen this run.
                if (r_err_count == '0) begin
                    r_first_err_vec  <= {bus.in_a, bus.in_b};
                    r_first_err_mask <= w_mask;
                end
            end
            if (w_finish) begin
                r_pass <= w_pass_next;
            end
        end
    end

    assign bus.in_ready       = w_in_ready;
    assign bus.busy           = w_busy;
    assign bus.done           = w_done;
    assign bus.pass           = r_pass;
    assign bus.vec_count      = r_vec_count;
    assign bus.err_count      = r_err_count;
    assign bus.first_err_vec  = r_first_err_vec;
    assign bus.first_err_mask = r_first_err_mask;
    assign bus.cover_bits     = r_cover;

endmodule
`default_nettype wire

// File: tb/tb_logic_gate_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logic_gate_checker
//  Description : Randomized bench for logic_gate_checker (continue/stop modes).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_gate_checker;

    localparam int CNT_W   = 8;
    localparam int NUM_VEC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic       in_a;
    logic       in_b;
    logic [6:0] in_resp;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    logic_gate_checker_if #(.CNT_W(CNT_W)) u_if0 ();
    logic_gate_checker_if #(.CNT_W(CNT_W)) u_if1 ();

    assign u_if0.start = start;  assign u_if1.start = start;
    assign u_if0.in_valid = in_valid;  assign u_if1.in_valid = in_valid;
    assign u_if0.in_a = in_a;  assign u_if1.in_a = in_a;
    assign u_if0.in_b = in_b;  assign u_if1.in_b = in_b;
    assign u_if0.in_resp = in_resp;  assign u_if1.in_resp = in_resp;

    logic_gate_checker #(.NUM_VEC(NUM_VEC), .CNT_W(CNT_W), .STOP_ON_ERR(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (u_if0)
    );

    logic_gate_checker #(.NUM_VEC(NUM_VEC), .CNT_W(CNT_W), .STOP_ON_ERR(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (u_if1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Truth table of the gate library, one gate per line.
    function automatic logic [6:0] gate_ref(input logic a, input logic b);
        logic [6:0] r;
        r[0] = a && b;
        r[1] = a || b;
        r[2] = !a;
        r[3] = !(a && b);
        r[4] = !(a || b);
        r[5] = (a != b);
        r[6] = (a == b);
        return r;
    endfunction

    // Field order: vec, err, fvec, fmask, cover, done, pass, ready, busy.
    task automatic check_dut(input int sel, input string what, input logic [31:0] e [9]);
        logic [31:0] g [9];
        string       names [9];
        names = '{"vec", "err", "fvec", "fmask", "cover", "done", "pass", "ready", "busy"};
        if (sel == 0) begin
            g = '{32'(u_if0.vec_count), 32'(u_if0.err_count), 32'(u_if0.first_err_vec),
                  32'(u_if0.first_err_mask), 32'(u_if0.cover_bits), 32'(u_if0.done),
                  32'(u_if0.pass), 32'(u_if0.in_ready), 32'(u_if0.busy)};
        end else begin
            g = '{32'(u_if1.vec_count), 32'(u_if1.err_count), 32'(u_if1.first_err_vec),
                  32'(u_if1.first_err_mask), 32'(u_if1.cover_bits), 32'(u_if1.done),
                  32'(u_if1.pass), 32'(u_if1.in_ready), 32'(u_if1.busy)};
        end
        for (int k = 0; k < 9; k++) begin
            check($sformatf("%s.dut%0d.%s", what, sel, names[k]), g[k], e[k]);
        end
    endtask

    task automatic check_zero(input string what);
        logic [31:0] z [9];
        z = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_dut(0, what, z);
        check_dut(1, what, z);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_vec(input logic [1:0] ab, input logic [6:0] fault);
        in_valid = 1'b1;
        in_a     = ab[1];
        in_b     = ab[0];
        in_resp  = gate_ref(ab[1], ab[0]) ^ fault;
        @(negedge clk);
        in_valid = 1'b0;
        {in_a, in_b} = 2'($urandom);
        in_resp  = 7'($urandom);
    endtask

    // One full run of four vectors; the model walks the vector list per DUT mode.
    task automatic do_run(input string what, input logic [7:0] ab_p, input logic [27:0] fm_p,
                          input bit gaps, input bit stray);
        logic [31:0] e [9];
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            if (stray && i == 2) begin
                pulse_start();
            end
            send_vec(ab_p[2*i +: 2], fm_p[7*i +: 7]);
        end
        for (int sel = 0; sel < 2; sel++) begin
            bit running = 1'b1;
            int v = 0, errs = 0, fv = 0, fm = 0, cov = 0, dn = 0, ps;
            for (int i = 0; i < 4; i++) begin
                if (running) begin
                    v++;
                    cov = cov | (1 << ab_p[2*i +: 2]);
                    if (fm_p[7*i +: 7] != 0) begin
                        if (errs == 0) begin
                            fv = ab_p[2*i +: 2];
                            fm = fm_p[7*i +: 7];
                        end
                        errs = (errs < 255) ? errs + 1 : 255;
                    end
                    if (v == NUM_VEC || (sel == 1 && fm_p[7*i +: 7] != 0)) begin
                        running = 1'b0;
                        dn = 1;
                    end
                end
            end
            ps = (dn == 1 && errs == 0 && cov == 15) ? 1 : 0;
            e = '{v, errs, fv, fm, cov, dn, ps, running ? 1 : 0, running ? 1 : 0};
            check_dut(sel, what, e);
            if (stray && sel == 1) begin
                send_vec(2'b11, 7'h00);
                check($sformatf("%s.dut0.vec_after_done", what), 32'(u_if0.vec_count), 32'(v));
                check($sformatf("%s.dut1.vec_after_done", what), 32'(u_if1.vec_count), 32'(v));
            end
        end
    endtask

    initial begin
        logic [7:0]  ab_p;
        logic [27:0] fm_p;
        bit          clean;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_a = 1'b0; in_b = 1'b0; in_resp = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        send_vec(2'b01, 7'h00);
        check_zero("idle_valid");

        do_run("exhaustive", {2'b11, 2'b10, 2'b01, 2'b00}, 28'h0, 1'b0, 1'b1);
        do_run("single_fault", {2'b11, 2'b10, 2'b01, 2'b00}, {7'h00, 7'h20, 7'h00, 7'h00}, 1'b0, 1'b0);
        do_run("stop_first", {2'b11, 2'b10, 2'b01, 2'b00}, {7'h00, 7'h00, 7'h00, 7'h01}, 1'b0, 1'b0);
        do_run("restart_pass", {2'b00, 2'b01, 2'b11, 2'b10}, 28'h0, 1'b1, 1'b0);
        do_run("partial_cover", 8'h00, 28'h0, 1'b0, 1'b0);
        do_run("gaps_stray", {2'b01, 2'b11, 2'b00, 2'b10}, 28'h0, 1'b1, 1'b1);

        pulse_start();
        send_vec(2'b00, 7'h00);
        send_vec(2'b11, 7'h00);
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;
        send_vec(2'b10, 7'h00);
        check_zero("post_reset_idle");

        do_run("fail_then", {2'b11, 2'b10, 2'b01, 2'b00}, {7'h7F, 7'h00, 7'h08, 7'h00}, 1'b0, 1'b0);
        do_run("restart_after_fail", {2'b10, 2'b00, 2'b11, 2'b01}, 28'h0, 1'b0, 1'b0);

        for (int r = 0; r < 30; r++) begin
            ab_p  = 8'($urandom);
            clean = 1'b1;
            for (int i = 0; i < 4; i++) begin
                fm_p[7*i +: 7] = ($urandom_range(0, 9) < 3) ? 7'($urandom_range(1, 127)) : 7'h00;
                if (fm_p[7*i +: 7] != 0) clean = 1'b0;
            end
            do_run($sformatf("rand%0d", r), ab_p, fm_p, $urandom_range(0, 1) == 1,
                   clean && ($urandom_range(0, 1) == 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
